ps2_rx: RTL and testbench

//  Receive-only PS/2 keyboard deserializer, upstream of the port controller's keyboard path.

---
 rtl/ps2_rx_pkg.sv | 21 ++
 rtl/ps2_rx_filter.sv | 52 +++++
 rtl/ps2_rx.sv | 133 +++++++++++++
 tb/tb_ps2_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encodings, frame size,
// and the stop-bit acceptance check.
package ps2_rx_pkg;

  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // A frame is good when the stop bit is high and data+parity has odd weight.
  function automatic logic frame_ok(input logic [FRAME_DATA_BITS-1:0] sr,
                                    input logic parity,
                                    input logic stop);
    return stop & (^{sr, parity});
  endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// Pin conditioner: 2-FF synchronizer followed by a run-length glitch filter.
// The filtered level only changes after FILTER_LEN consecutive synchronized
// samples disagree with it; fall pulses for one cycle on a 1->0 change.
module ps2_rx_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] run_cnt;

  // Two-stage synchronizer; resets to the idle-bus level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

  // Count disagreeing samples; flip the level on the FILTER_LEN-th one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level   <= 1'b1;
      fall    <= 1'b0;
      run_cnt <= '0;
    end else if (sync != level) begin
      if (run_cnt == CW'(FILTER_LEN - 1)) begin
        level   <= sync;
        fall    <= level;
        run_cnt <= '0;
      end else begin
        fall    <= 1'b0;
        run_cnt <= run_cnt + CW'(1);
      end
    end else begin
      fall    <= 1'b0;
      run_cnt <= '0;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// Receive-only PS/2 deserializer. Each valid 11-bit frame (start, 8 data
// LSB-first, odd parity, stop) yields one byte on ps2_data with a one-cycle
// ps2_hit; parity, stop or mid-frame timeout failures pulse ps2_err.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | waiting for a start bit (data low on a clock fall)
//  ST_DATA   | shifting in the 8 data bits, LSB first
//  ST_PARITY | next fall carries the parity bit
//  ST_STOP   | next fall carries the stop bit; frame is judged here
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 10000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_hit,
  output logic       ps2_err
);

  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int CNTW = $clog2(FRAME_DATA_BITS + 1);

  logic bit_evt;
  logic dat;
  logic clk_level;
  logic dat_fall;
  logic unused_filter;

  state_t                     state;
  state_t                     state_nxt;
  logic [FRAME_DATA_BITS-1:0] sr;
  logic [CNTW-1:0]            bit_cnt;
  logic                       parity_bit;
  logic [TW-1:0]              to_cnt;

  logic start_ok;
  logic shift_en;
  logic par_en;
  logic stop_ok;
  logic stop_bad;
  logic timeout_hit;

  ps2_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (ps2_clk),
    .level   (clk_level),
    .fall    (bit_evt)
  );

  ps2_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (ps2_dat),
    .level   (dat),
    .fall    (dat_fall)
  );

  // The clock level and data edge are not needed by the frame logic.
  assign unused_filter = clk_level ^ dat_fall;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: advance on bit events; a timeout from any active state aborts.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (bit_evt && !dat) state_nxt = ST_DATA;
      ST_DATA:   if (bit_evt && bit_cnt == CNTW'(FRAME_DATA_BITS - 1)) state_nxt = ST_PARITY;
      ST_PARITY: if (bit_evt) state_nxt = ST_STOP;
      ST_STOP:   if (bit_evt) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (timeout_hit) state_nxt = ST_IDLE;
  end

  // Per-state strobes; a bit event in the expiry cycle suppresses the timeout.
  always_comb begin
    start_ok    = (state == ST_IDLE)   && bit_evt && !dat;
    shift_en    = (state == ST_DATA)   && bit_evt;
    par_en      = (state == ST_PARITY) && bit_evt;
    stop_ok     = (state == ST_STOP)   && bit_evt &&  frame_ok(sr, parity_bit, dat);
    stop_bad    = (state == ST_STOP)   && bit_evt && !frame_ok(sr, parity_bit, dat);
    timeout_hit = (state != ST_IDLE)   && !bit_evt && (to_cnt == TW'(TIMEOUT - 1));
  end

  // Shift register, bit counter and parity capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr         <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else begin
      if (start_ok) bit_cnt <= '0;
      if (shift_en) begin
        sr      <= {dat, sr[FRAME_DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + CNTW'(1);
      end
      if (par_en) parity_bit <= dat;
    end
  end

  // Inactivity counter: idle-held, cleared by every bit event and on expiry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                      to_cnt <= '0;
    else if (state == ST_IDLE || bit_evt || timeout_hit) to_cnt <= '0;
    else                                               to_cnt <= to_cnt + TW'(1);
  end

  // Registered outputs; ps2_data only moves on a good frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps2_data <= '0;
      ps2_hit  <= 1'b0;
      ps2_err  <= 1'b0;
    end else begin
      ps2_hit <= stop_ok;
      ps2_err <= stop_bad | timeout_hit;
      if (stop_ok) ps2_data <= sr;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: a PS/2 device model drives frames (clock period scaled to
// 100 system cycles, data changing mid-high); expected hits/errors go into a
// scoreboard queue and are popped when the DUT strobes.
module tb_ps2_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 10000;
  localparam int HALF       = 50;
  localparam int QH         = 25;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_data;
  logic       ps2_hit;
  logic       ps2_err;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  logic prev_hit = 1'b0;
  logic prev_err = 1'b0;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .ps2_data (ps2_data),
    .ps2_hit  (ps2_hit),
    .ps2_err  (ps2_err)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    return {stop, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  // Drive bits first..last of a frame; optional 3-cycle clock glitch in the high phase.
  task automatic send_bits(input logic [10:0] bits, input int first, input int last, input int glitch_bit);
    for (int i = first; i <= last; i++) begin
      if (i == glitch_bit) begin
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(QH - 8);
      end else begin
        wait_cyc(QH);
      end
      ps2_dat = bits[i];
      wait_cyc(QH);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] bits, input int glitch_bit);
    send_bits(bits, 0, 10, glitch_bit);
    ps2_dat = 1'b1;
    wait_cyc(200);
  endtask

  task automatic expect_evt(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    sb_q.push_back(e);
  endtask

  // Monitor: pop the scoreboard on every strobe, check pulse widths and latency.
  always @(negedge clock) begin
    if (reset_n) begin
      if (ps2_hit || ps2_err) begin
        check_eq("hit_err_excl", {31'd0, ps2_hit & ps2_err}, 32'd0);
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected", sb_q.size(), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("evt_kind", {31'd0, ps2_err}, {31'd0, e.is_err});
          check_eq("evt_data", {24'd0, ps2_data}, {24'd0, e.data});
          if (ps2_hit) check_eq("hit_latency", cyc - last_fall_cyc, FILTER_LEN + 3);
        end
      end
      if (prev_hit) check_eq("hit_width", {31'd0, ps2_hit}, 32'd0);
      if (prev_err) check_eq("err_width", {31'd0, ps2_err}, 32'd0);
    end
    prev_hit = ps2_hit;
    prev_err = ps2_err;
  end

  initial begin
    logic [10:0] f;

    // Reset state
    wait_cyc(3);
    @(negedge clock);
    check_eq("rst_data", {24'd0, ps2_data}, 32'd0);
    check_eq("rst_hit",  {31'd0, ps2_hit},  32'd0);
    check_eq("rst_err",  {31'd0, ps2_err},  32'd0);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(50);

    // 1: single good frame
    expect_evt(1'b0, 8'h1C);
    send_frame(make_frame(8'h1C, 1'b0, 1'b1), -1);

    // 2: back-to-back frames
    expect_evt(1'b0, 8'hF0);
    send_bits(make_frame(8'hF0, 1'b0, 1'b1), 0, 10, -1);
    expect_evt(1'b0, 8'h1C);
    send_frame(make_frame(8'h1C, 1'b0, 1'b1), -1);

    // 3: parity error, then stop-bit error; data is retained
    expect_evt(1'b1, 8'h1C);
    send_frame(make_frame(8'h1C, 1'b1, 1'b1), -1);
    expect_evt(1'b1, 8'h1C);
    send_frame(make_frame(8'h1C, 1'b0, 1'b0), -1);

    // 4: timeout after start + 4 data bits, then recovery
    expect_evt(1'b1, 8'h1C);
    send_bits(make_frame(8'h3C, 1'b0, 1'b1), 0, 4, -1);
    ps2_dat = 1'b1;
    wait_cyc(TIMEOUT + 10);
    check_eq("timeout_drained", sb_q.size(), 0);
    expect_evt(1'b0, 8'h5A);
    send_frame(make_frame(8'h5A, 1'b0, 1'b1), -1);

    // 5: glitches in idle and mid-frame
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(100);
    expect_evt(1'b0, 8'h76);
    send_frame(make_frame(8'h76, 1'b0, 1'b1), 4);

    // 6: reset mid-frame after bit 5; remaining edges must be ignored
    f = make_frame(8'hE1, 1'b0, 1'b1);
    send_bits(f, 0, 5, -1);
    wait_cyc(5);
    reset_n = 1'b0;
    @(negedge clock);
    check_eq("midrst_data", {24'd0, ps2_data}, 32'd0);
    check_eq("midrst_hit",  {31'd0, ps2_hit},  32'd0);
    check_eq("midrst_err",  {31'd0, ps2_err},  32'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    send_bits(f, 6, 10, -1);
    ps2_dat = 1'b1;
    wait_cyc(200);
    check_eq("midrst_quiet", sb_q.size(), 0);
    expect_evt(1'b0, 8'h29);
    send_frame(make_frame(8'h29, 1'b0, 1'b1), -1);

    wait_cyc(100);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
